// File: rtl/v8cpu_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : v8cpu_writeback_if
// Brief    : ALU result, load result, register read and status bundle for the
//            v8cpu writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
interface v8cpu_writeback_if;
  logic       alu_valid;
  logic       alu_ready;
  logic [2:0] alu_dst;
  logic [7:0] alu_c;
  logic [7:0] alu_newFlags;
  logic       alu_wr_reg;
  logic       alu_wr_flags;

  logic       ld_valid;
  logic       ld_ready;
  logic [2:0] ld_dst;
  logic [7:0] ld_data;

  logic [2:0] rd_a_addr;
  logic [2:0] rd_b_addr;
  logic [7:0] rd_a_data;
  logic [7:0] rd_b_data;

  logic [7:0] flags;
  logic [7:0] conflict_cnt;

  modport master (
    output alu_valid, alu_dst, alu_c, alu_newFlags, alu_wr_reg, alu_wr_flags,
    output ld_valid, ld_dst, ld_data, rd_a_addr, rd_b_addr,
    input  alu_ready, ld_ready, rd_a_data, rd_b_data, flags, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_dst, alu_c, alu_newFlags, alu_wr_reg, alu_wr_flags,
    input  ld_valid, ld_dst, ld_data, rd_a_addr, rd_b_addr,
    output alu_ready, ld_ready, rd_a_data, rd_b_data, flags, conflict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/v8cpu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : v8cpu_writeback
// Brief    : 8x8 register file with flags, ALU write port and a one-entry
//            buffered load port that yields to ALU writes.
// Revision : 1.0 - initial release
// ============================================================================
module v8cpu_writeback #(
  parameter logic [7:0] FLAGS_RESET = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  v8cpu_writeback_if.slave bus
);

  logic [7:0] r_regs [8];
  logic [7:0] r_flags;
  logic       r_bufValid;
  logic [2:0] r_bufDst;
  logic [7:0] r_bufData;
  logic [7:0] r_conflictCnt;

  logic       w_aluWr;
  logic       w_drain;
  logic       w_ldReady;
  logic       w_ldAccept;
  logic       w_wrEn;
  logic [2:0] w_wrAddr;
  logic [7:0] w_wrData;

  // The single register write port goes to the ALU first; the buffer drains only when it is idle.
  assign w_aluWr    = bus.alu_valid & bus.alu_wr_reg;
  assign w_drain    = r_bufValid & ~w_aluWr;
  assign w_ldReady  = ~r_bufValid | w_drain;
  assign w_ldAccept = bus.ld_valid & w_ldReady;
  assign w_wrEn     = w_aluWr | w_drain;
  assign w_wrAddr   = w_aluWr ? bus.alu_dst : r_bufDst;
  assign w_wrData   = w_aluWr ? bus.alu_c   : r_bufData;

  assign bus.alu_ready    = 1'b1;
  assign bus.ld_ready     = w_ldReady;
  assign bus.flags        = r_flags;
  assign bus.conflict_cnt = r_conflictCnt;

  always_comb begin
    bus.rd_a_data = r_regs[bus.rd_a_addr];
    if (w_wrEn && (w_wrAddr == bus.rd_a_addr)) begin
      bus.rd_a_data = w_wrData;
    end
  end

  always_comb begin
    bus.rd_b_data = r_regs[bus.rd_b_addr];
    if (w_wrEn && (w_wrAddr == bus.rd_b_addr)) begin
      bus.rd_b_data = w_wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_wrEn) begin
      r_regs[w_wrAddr] <= w_wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= FLAGS_RESET;
    end else if (bus.alu_valid && bus.alu_wr_flags) begin
      r_flags <= bus.alu_newFlags;
    end
  end

  // An accept in the same cycle as a drain refills the buffer without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bufValid <= 1'b0;
      r_bufDst   <= 3'd0;
      r_bufData  <= 8'h00;
    end else if (w_ldAccept) begin
      r_bufValid <= 1'b1;
      r_bufDst   <= bus.ld_dst;
      r_bufData  <= bus.ld_data;
    end else if (w_drain) begin
      r_bufValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflictCnt <= 8'h00;
    end else if (r_bufValid && w_aluWr && (r_conflictCnt != 8'hFF)) begin
      r_conflictCnt <= r_conflictCnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/v8cpu_writeback.md
V8CPU_WRITEBACK -- requirements
Module: v8cpu_writeback

Interface
REQ-001 The block SHALL have one parameter: FLAGS_RESET, default 8'h00, value loaded into the flags register on reset.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 alu_valid  in  1  an ALU result is presented this cycle.
REQ-006 alu_ready  out  1  tied high; an ALU result is always accepted.
REQ-007 alu_dst  in  3  destination register index.
REQ-008 alu_c  in  8  ALU result value.
REQ-009 alu_newFlags  in  8  ALU-computed flags.
REQ-010 alu_wr_reg  in  1  write alu_c to alu_dst.
REQ-011 alu_wr_flags  in  1  write alu_newFlags to the flags register.
REQ-012 ld_valid  in  1  a memory-load result is offered.
REQ-013 ld_ready  out  1  the load port accepts this cycle.
REQ-014 ld_dst  in  3  load destination register index.
REQ-015 ld_data  in  8  load data.
REQ-016 rd_a_addr, rd_b_addr  in  3 each  read addresses (ALU operands a and b).
REQ-017 rd_a_data, rd_b_data  out  8 each  read data feeding ALU a and b.
REQ-018 flags  out  8  current flags register, feeding the ALU flags input.
REQ-019 conflict_cnt  out  8  saturating count of load-blocked cycles.

Function
REQ-020 Storage SHALL consist of 8 x 8-bit registers, one 8-bit flags register, a one-entry load buffer (valid, dst, data), and conflict_cnt.
REQ-021 ALU write: when alu_valid & alu_wr_reg, regs[alu_dst] SHALL take alu_c at the next edge.
REQ-022 Flags write: when alu_valid & alu_wr_flags, flags SHALL take alu_newFlags at the next edge; these bits are independent of alu_wr_reg.
REQ-023 Load accept: a load transfer SHALL occur when ld_valid & ld_ready; the transferred data enters the load buffer.
REQ-024 The load buffer SHALL drain (regs[buf_dst] <= buf_data, buf_valid cleared) in any cycle where it is valid and (alu_valid & alu_wr_reg) is low.
REQ-025 ld_ready SHALL equal !buf_valid | drain_this_cycle, computed combinationally.
REQ-026 Simultaneous drain and accept SHALL leave the buffer valid with the new entry, with no bubble.
REQ-027 An ALU register write SHALL always take priority over a buffer drain; only one register write occurs per cycle.
REQ-028 Read ports SHALL be combinational with write-through bypass: if the address matches the register being written this cycle (ALU or drain), the read returns that write data; otherwise it returns the array value.
REQ-029 flags output SHALL show the registered value only, with no bypass.
REQ-030 conflict_cnt SHALL increment by 1 each cycle in which buf_valid & alu_valid & alu_wr_reg, saturating at 8'hFF (no wrap).
REQ-031 Writes with alu_valid low SHALL be ignored regardless of alu_wr_reg and alu_wr_flags.
REQ-032 All 8 registers SHALL be writable; there is no hard-wired zero register.

Reset
REQ-033 While rst is high: all registers 8'h00, flags = FLAGS_RESET, buf_valid = 0, conflict_cnt = 0, ld_ready = 1.
REQ-034 Reset asserted mid-operation SHALL discard a buffered load without writing it.
REQ-035 The first write SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-036 Reset, then read all 8 addresses -> 8'h00 each; flags = 8'h00; ld_ready = 1.
REQ-037 ALU write dst=3, c=8'd36, wr_flags with newFlags=8'h01 -> same cycle rd_a_addr=3 returns 36 (bypass); next cycle regs[3]=36 and flags=8'h01.
REQ-038 Load dst=5, data=8'hA5 with no ALU activity -> accepted; regs[5]=8'hA5 two edges later; ld_ready stays 1.
REQ-039 Load dst=2, data=8'h11 buffered, then 3 consecutive ALU writes -> ld_ready = 0 for those cycles and conflict_cnt = 3; the drain occurs the cycle after the ALU stops; regs[2]=8'h11.
REQ-040 Hold buffer-blocked for 300 cycles -> conflict_cnt = 8'hFF and does not wrap.
REQ-041 Assert rst while the buffer holds dst=6, data=8'h7E -> after reset regs[6]=8'h00 and buf_valid = 0.
